// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges the IF and DM CPU ports onto one registered, wait-stated mem_* bus
module mem_bus_arbiter #(
   parameter int unsigned WAIT_CYCLES      = 1,
   parameter logic [31:0] SERIAL_DATA_ADDR = 32'hBFD003F8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_sel_n,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        stall_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we_n,
   output logic [3:0]  mem_sel_n,
   output logic        mem_ce_i,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] W = 4'(WAIT_CYCLES);
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_dm;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we_n;
   logic [3:0]  r_sel_n;
   logic        r_ce;
   logic        r_if_ack;
   logic        r_dm_ack;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dm_rdata;
   logic [31:0] w_addr;
   logic        w_serial;
   assign w_addr    = dm_req ? dm_addr : if_addr;
   assign w_serial  = w_addr == SERIAL_DATA_ADDR;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we_n  = r_we_n;
   assign mem_sel_n = r_sel_n;
   assign mem_ce_i  = r_ce;
   assign if_ack    = r_if_ack;
   assign dm_ack    = r_dm_ack;
   assign if_rdata  = r_if_rdata;
   assign dm_rdata  = r_dm_rdata;
   assign stall_req = (if_req & ~r_if_ack) | (dm_req & ~r_dm_ack);
   // grant (DM first), hold the access for its wait count, then pulse the owner's ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_dm       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we_n     <= 1'b1;
         r_sel_n    <= 4'hF;
         r_ce       <= 1'b0;
         r_if_ack   <= 1'b0;
         r_dm_ack   <= 1'b0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_if_ack <= 1'b0;
               r_dm_ack <= 1'b0;
               if (dm_req | if_req) begin
                  r_state <= ACCESS;
                  r_dm    <= dm_req;
                  r_addr  <= w_addr;
                  r_wdata <= dm_req ? dm_wdata : '0;
                  r_we_n  <= ~(dm_req & dm_we);
                  r_sel_n <= dm_req ? dm_sel_n : 4'h0;
                  r_ce    <= 1'b1;
                  r_cnt   <= w_serial ? 4'd0 : W;
               end
            end
            ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
                  r_ce    <= 1'b0;
                  r_we_n  <= 1'b1;
                  r_sel_n <= 4'hF;
                  if (r_dm) begin
                     r_dm_ack <= 1'b1;
                     if (r_we_n) r_dm_rdata <= mem_rdata;
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               r_if_ack <= 1'b0;
               r_dm_ack <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for the IF/DM memory bus arbiter
module tb_mem_bus_arbiter;
   localparam int          W   = 1;
   localparam logic [31:0] SER = 32'hBFD003F8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [3:0]  dm_sel_n = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        stall_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we_n;
   logic [3:0]  mem_sel_n;
   logic        mem_ce_i;
   logic [31:0] mem_rdata;
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] last_dm = '0;

   typedef struct {logic [31:0] addr; logic [31:0] wdata; logic we_n; logic [3:0] sel_n; bit cw; int start; int len;} bus_t;
   typedef struct {int cyc; logic [31:0] rdata;} ack_t;
   bus_t bus_q[$];
   ack_t if_q[$];
   ack_t dm_q[$];

   function automatic logic [31:0] bus_data(logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h12345678;
   endfunction

   assign mem_rdata = bus_data(mem_addr);

   mem_bus_arbiter #(.WAIT_CYCLES(W), .SERIAL_DATA_ADDR(SER)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_sel_n(dm_sel_n), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall_req(stall_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n),
      .mem_sel_n(mem_sel_n), .mem_ce_i(mem_ce_i), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic unexpected(string nm);
      nvec++;
      nerr++;
      $display("FAIL %s at cycle %0d: event with no expected entry", nm, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bus monitor: one record per mem_ce_i burst, checked against the expected access list
   initial begin
      bus_t cur;
      bus_t e;
      bit   act;
      bit   moved;
      act = 0;
      moved = 0;
      cur = '{addr: '0, wdata: '0, we_n: 1'b1, sel_n: 4'hF, cw: 0, start: 0, len: 0};
      forever begin
         @(negedge clk);
         if (rst) act = 0;
         else if (mem_ce_i) begin
            if (!act) begin
               act = 1;
               moved = 0;
               cur = '{addr: mem_addr, wdata: mem_wdata, we_n: mem_we_n, sel_n: mem_sel_n, cw: 0, start: cyc, len: 1};
            end else begin
               cur.len++;
               if (mem_addr !== cur.addr || mem_wdata !== cur.wdata || mem_we_n !== cur.we_n || mem_sel_n !== cur.sel_n) moved = 1;
            end
         end else begin
            chk("idle_we_n", 32'(mem_we_n), 32'd1);
            if (act) begin
               act = 0;
               if (bus_q.size() == 0) unexpected("bus_access");
               else begin
                  e = bus_q.pop_front();
                  chk("bus_addr", cur.addr, e.addr);
                  chk("bus_we_n", 32'(cur.we_n), 32'(e.we_n));
                  chk("bus_sel_n", 32'(cur.sel_n), 32'(e.sel_n));
                  if (e.cw) chk("bus_wdata", cur.wdata, e.wdata);
                  chk("bus_start", 32'(cur.start), 32'(e.start));
                  chk("bus_len", 32'(cur.len), 32'(e.len));
                  chk("bus_stable", 32'(moved), 32'd0);
               end
            end
         end
      end
   end

   // ack monitor: each ack pops the port's expected completion cycle and data
   initial begin
      ack_t e;
      forever begin
         @(negedge clk);
         if (!rst && if_ack) begin
            if (if_q.size() == 0) unexpected("if_ack");
            else begin
               e = if_q.pop_front();
               chk("if_ack_cyc", 32'(cyc), 32'(e.cyc));
               chk("if_rdata", if_rdata, e.rdata);
            end
         end
         if (!rst && dm_ack) begin
            if (dm_q.size() == 0) unexpected("dm_ack");
            else begin
               e = dm_q.pop_front();
               chk("dm_ack_cyc", 32'(cyc), 32'(e.cyc));
               chk("dm_rdata", dm_rdata, e.rdata);
            end
         end
      end
   end

   // one round: optional IF and DM requests arriving at offsets ai/ad from an idle cycle T
   task automatic round(bit hi, int ai, logic [31:0] ia, bit hd, int ad, bit dwe,
                        logic [31:0] da, logic [31:0] dw, logic [3:0] ds);
      int   t, c, fi, eif, edm, w;
      bit   ip, dp, idone, ddone;
      bus_t b;
      ack_t k;
      tick();
      t = cyc;
      ip = hi;
      dp = hd;
      fi = t;
      eif = -1;
      edm = -1;
      while (ip || dp) begin
         c = fi;
         if (!(dp && t + ad <= c) && !(ip && t + ai <= c))
            c = (dp && (!ip || ad < ai)) ? t + ad : t + ai;
         if (dp && t + ad <= c) begin
            w = (da == SER) ? 0 : W;
            b = '{addr: da, wdata: dw, we_n: !dwe, sel_n: ds, cw: 1, start: c + 1, len: w + 1};
            bus_q.push_back(b);
            edm = c + 2 + w;
            k.cyc = edm;
            k.rdata = dwe ? last_dm : bus_data(da);
            last_dm = k.rdata;
            dm_q.push_back(k);
            dp = 0;
         end else begin
            w = (ia == SER) ? 0 : W;
            b = '{addr: ia, wdata: '0, we_n: 1'b1, sel_n: 4'h0, cw: 0, start: c + 1, len: w + 1};
            bus_q.push_back(b);
            eif = c + 2 + w;
            k.cyc = eif;
            k.rdata = bus_data(ia);
            if_q.push_back(k);
            ip = 0;
         end
         fi = c + 3 + w;
      end
      idone = !hi;
      ddone = !hd;
      for (int n = 0; n < 80 && !(idone && ddone); n++) begin
         c = cyc;
         chk("stall_req", 32'(stall_req), 32'((if_req && c != eif) || (dm_req && c != edm)));
         if (if_req && if_ack) begin if_req = 0; idone = 1; end
         if (dm_req && dm_ack) begin dm_req = 0; ddone = 1; end
         if (hi && !idone && c == t + ai) begin if_req = 1; if_addr = ia; end
         if (hd && !ddone && c == t + ad) begin
            dm_req = 1; dm_we = dwe; dm_addr = da; dm_wdata = dw; dm_sel_n = ds;
         end
         if (!(idone && ddone)) tick();
      end
      if (!(idone && ddone)) begin
         nvec++;
         nerr++;
         $display("FAIL round_timeout from cycle %0d: if_done %0d dm_done %0d required 1 1", t, idone, ddone);
         if_req = 0;
         dm_req = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      chk("rst_ce", 32'(mem_ce_i), 32'd0);
      chk("rst_we_n", 32'(mem_we_n), 32'd1);
      chk("rst_sel_n", 32'(mem_sel_n), 32'hF);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      tick();
      rst = 0;
      round(1, 0, 32'h80000010, 0, 0, 0, '0, '0, '0);
      round(1, 0, 32'h80000100, 1, 0, 0, 32'h80400000, 32'h0, 4'h0);
      round(0, 0, '0, 1, 0, 1, SER, 32'h41, 4'h0);
      round(0, 0, '0, 1, 0, 1, 32'h80400004, 32'hA5, 4'hE);
      for (int i = 0; i < 3; i++) round(1, 0, 32'h80001000 + 32'(i * 4), 0, 0, 0, '0, '0, '0);
      round(1, 0, SER, 0, 0, 0, '0, '0, '0);
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         round(kind != 1, int'($urandom_range(0, 3)), {$urandom} & 32'hFFFF_FFFC,
               kind != 0, int'($urandom_range(0, 3)), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? SER : $urandom, $urandom, 4'($urandom));
      end
      tick();
      if_req = 1;
      if_addr = 32'h80000020;
      tick();
      chk("ce_before_rst", 32'(mem_ce_i), 32'd1);
      #2 rst = 1;
      #1;
      chk("midrst_ce", 32'(mem_ce_i), 32'd0);
      chk("midrst_we_n", 32'(mem_we_n), 32'd1);
      chk("midrst_sel_n", 32'(mem_sel_n), 32'hF);
      chk("midrst_addr", mem_addr, 32'd0);
      if_req = 0;
      last_dm = '0;
      tick();
      tick();
      chk("midrst_no_ack", 32'({if_ack, dm_ack}), 32'd0);
      rst = 0;
      round(1, 0, 32'h80000010, 0, 0, 0, '0, '0, '0);
      round(0, 0, '0, 1, 1, 0, 32'h80400008, 32'h0, 4'h3);
      repeat (5) tick();
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("if_q_drained", 32'(if_q.size()), 32'd0);
      chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
